mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
- REQ-001 SHALL have one clock and an asynchronous, active-low reset; all other signals are synchronous to clk. Ports:
  - clk  input  1  core clock; all state updates on rising edge.
  - rstn  input  1  asynchronous active-low reset.
  - mX_req (X=0,1)  input  1  master X request; held high, fields stable, until mX_done. m0 = mem stage, m1 = fetch refill.
  - mX_we  input  1  1 = write, 0 = read.
  - mX_addr  input  32  byte address.
  - mX_wdata  input  32  write data.
  - mX_wstrb  input  4  write byte enables.
  - mX_done  output  1  one-cycle completion pulse to master X.
  - mX_rdata  output  32  read data, valid while mX_done=1.
  - s_req  output  1  downstream request; held until s_ack.
  - s_we  output  1  downstream write flag.
  - s_addr  output  32  downstream address.
  - s_wdata  output  32  downstream write data.
  - s_wstrb  output  4  downstream strobes; 4'b0000 on reads.
  - s_ack  input  1  one-cycle downstream completion pulse.
  - s_rdata  input  32  downstream read data, valid with s_ack.

Function
- REQ-002 SHALL implement FSM IDLE -> BUSY -> RESP -> IDLE, one transaction in flight at a time.
- REQ-003 IDLE: if any mX_req=1, SHALL select one winner, latch its we/addr/wdata/wstrb and index into internal registers, and enter BUSY next cycle; otherwise stay IDLE.
- REQ-004 BUSY: SHALL drive s_req=1 and s_we/s_addr/s_wdata/s_wstrb from latched registers only; changes on mX inputs during BUSY SHALL have no effect.
- REQ-005 BUSY with s_ack=1: SHALL latch s_rdata (writes: latch 0) and enter RESP; s_req SHALL be 0 in RESP.
- REQ-006 RESP: SHALL assert done and drive rdata of the winner only for exactly one cycle, then return to IDLE.
- REQ-007 Non-winner mX_done SHALL stay 0; non-winner mX_rdata SHALL be 32'h0.
- REQ-008 Masters deassert req in the cycle after done; arbiter SHALL not resample requests in RESP, so no double grant occurs.
- REQ-009 Latency: req sampled in IDLE at cycle 0 -> s_req at cycle 1 -> s_ack at cycle k (k>=1) -> mX_done at cycle k+1; zero-wait downstream gives a 3-cycle round trip.
- REQ-010 A request pending during BUSY/RESP SHALL be held off, not dropped, and granted in the next IDLE per priority rule.
- REQ-011 s_ack while not in BUSY SHALL be ignored.
- REQ-012 s_wstrb SHALL be 4'b0000 whenever s_we=0 regardless of mX_wstrb.

Reset
- REQ-013 While rstn=0: state=IDLE, s_req=0, s_we=0, s_addr=0, s_wdata=0, s_wstrb=0, mX_done=0, mX_rdata=0, latched registers 0, round-robin pointer = m0 preferred.
- REQ-014 Reset assertion mid-transaction SHALL drop s_req asynchronously; the aborted transaction SHALL not produce mX_done after reset release.

Configuration
- REQ-015 Macro MEM_ARBITER_RR_EN:
  - Defined: round-robin. When both request in IDLE, the master not granted last wins; the pointer updates on each grant.
  - Undefined: fixed priority, m0 always wins ties; no pointer state is present.

Verification
- REQ-016 m0 read only, addr=0x100, s_ack at cycle 1 with s_rdata=0xDEADBEEF -> s_req high cycle 1 only, m0_done and m0_rdata=0xDEADBEEF at cycle 2, m1_done=0.
- REQ-017 m1 write addr=0x40, wdata=0x12345678, wstrb=4'b0011, s_ack delayed 5 cycles -> s_* stable all 5 cycles, s_wstrb=4'b0011, m1_done one cycle after s_ack, m1_rdata=0.
- REQ-018 Both request continuously for 4 transactions:
  - with MEM_ARBITER_RR_EN -> grant order m0,m1,m0,m1;
  - without it -> m0 granted every time while it requests, m1 only after m0 drops req.
- REQ-019 m0 read with mX_wstrb=4'b1111 -> s_wstrb=4'b0000; spurious s_ack in IDLE -> no mX_done.
- REQ-020 rstn pulled low during BUSY -> s_req=0 immediately; after release with no req -> stays IDLE, no done pulse.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bundle of two requesting masters and one downstream memory port.
// The slave modport is the arbiter's view; the master modport is the
// view of whatever surrounds the arbiter (masters plus downstream memory).
interface mem_arbiter_if;
    logic        m0_req;
    logic        m0_we;
    logic [31:0] m0_addr;
    logic [31:0] m0_wdata;
    logic [3:0]  m0_wstrb;
    logic        m0_done;
    logic [31:0] m0_rdata;

    logic        m1_req;
    logic        m1_we;
    logic [31:0] m1_addr;
    logic [31:0] m1_wdata;
    logic [3:0]  m1_wstrb;
    logic        m1_done;
    logic [31:0] m1_rdata;

    logic        s_req;
    logic        s_we;
    logic [31:0] s_addr;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_ack;
    logic [31:0] s_rdata;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata, m0_wstrb,
        output m0_done, m0_rdata,
        input  m1_req, m1_we, m1_addr, m1_wdata, m1_wstrb,
        output m1_done, m1_rdata,
        output s_req, s_we, s_addr, s_wdata, s_wstrb,
        input  s_ack, s_rdata
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata, m0_wstrb,
        input  m0_done, m0_rdata,
        output m1_req, m1_we, m1_addr, m1_wdata, m1_wstrb,
        input  m1_done, m1_rdata,
        input  s_req, s_we, s_addr, s_wdata, s_wstrb,
        output s_ack, s_rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-master memory arbiter: m0 (mem stage) and m1 (fetch refill) share one
// downstream port, one transaction in flight (IDLE -> BUSY -> RESP -> IDLE).
// Optional feature macro MEM_ARBITER_RR_EN: when defined, ties are broken
// round-robin; when undefined, m0 always wins ties and no pointer exists.
module mem_arbiter (
    input  logic           clk,
    input  logic           rstn,
    mem_arbiter_if.slave   bus
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]  state;
    logic        any_req;
    logic        winner;

    logic        sel_we;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic [3:0]  sel_wstrb;

    logic        lat_idx;
    logic        lat_we;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [3:0]  lat_wstrb;
    logic [31:0] lat_rdata;
    logic        resp;

    assign any_req = bus.m0_req | bus.m1_req;

`ifdef MEM_ARBITER_RR_EN
    logic last_grant;

    // On a tie the master that was not granted last wins; otherwise the lone requester.
    always_comb begin
        winner = 1'b0;
        if (bus.m0_req && bus.m1_req) begin
            winner = ~last_grant;
        end else begin
            winner = bus.m1_req;
        end
    end

    // Pointer remembers the last grant; reset value makes m0 the preferred master.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            last_grant <= 1'b1;
        end else if (state == IDLE && any_req) begin
            last_grant <= winner;
        end
    end
`else
    // Fixed priority: m1 only wins when m0 is not asking.
    assign winner = ~bus.m0_req;
`endif

    // Route the winning master's request fields toward the capture registers.
    always_comb begin
        sel_we    = bus.m0_we;
        sel_addr  = bus.m0_addr;
        sel_wdata = bus.m0_wdata;
        sel_wstrb = bus.m0_wstrb;
        if (winner) begin
            sel_we    = bus.m1_we;
            sel_addr  = bus.m1_addr;
            sel_wdata = bus.m1_wdata;
            sel_wstrb = bus.m1_wstrb;
        end
    end

    // Transaction FSM; request fields are captured once at grant so later master changes are ignored.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            lat_idx   <= 1'b0;
            lat_we    <= 1'b0;
            lat_addr  <= 32'h0;
            lat_wdata <= 32'h0;
            lat_wstrb <= 4'h0;
            lat_rdata <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        lat_idx   <= winner;
                        lat_we    <= sel_we;
                        lat_addr  <= sel_addr;
                        lat_wdata <= sel_wdata;
                        lat_wstrb <= sel_wstrb;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (bus.s_ack) begin
                        lat_rdata <= lat_we ? 32'h0 : bus.s_rdata;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Downstream request exists only in BUSY, so an async reset drops it immediately.
    assign bus.s_req   = (state == BUSY);
    assign bus.s_we    = lat_we;
    assign bus.s_addr  = lat_addr;
    assign bus.s_wdata = lat_wdata;
    assign bus.s_wstrb = lat_we ? lat_wstrb : 4'b0000;

    // Completion goes only to the captured winner; the other master sees zeros.
    assign resp         = (state == RESP);
    assign bus.m0_done  = resp & ~lat_idx;
    assign bus.m1_done  = resp & lat_idx;
    assign bus.m0_rdata = bus.m0_done ? lat_rdata : 32'h0;
    assign bus.m1_rdata = bus.m1_done ? lat_rdata : 32'h0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: drives both masters and plays the
// downstream memory, queueing the expected completion of every grant.
module tb_mem_arbiter;

    typedef struct {
        logic        idx;
        logic [31:0] rdata;
    } exp_t;

    logic clk = 1'b0;
    logic rstn;
    exp_t exp_q[$];
    int   compared   = 0;
    int   mismatched = 0;

    mem_arbiter_if bus();

    mem_arbiter dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    // 10-unit clock period.
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic zero_inputs();
        bus.m0_req = 1'b0; bus.m0_we = 1'b0; bus.m0_addr = 32'h0; bus.m0_wdata = 32'h0; bus.m0_wstrb = 4'h0;
        bus.m1_req = 1'b0; bus.m1_we = 1'b0; bus.m1_addr = 32'h0; bus.m1_wdata = 32'h0; bus.m1_wstrb = 4'h0;
        bus.s_ack  = 1'b0; bus.s_rdata = 32'h0;
    endtask

    task automatic set_fields(input logic idx, input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb);
        if (idx) begin
            bus.m1_addr = addr; bus.m1_wdata = wdata; bus.m1_wstrb = wstrb;
        end else begin
            bus.m0_addr = addr; bus.m0_wdata = wdata; bus.m0_wstrb = wstrb;
        end
    endtask

    task automatic apply_stimulus(input logic idx, input logic we, input logic [31:0] addr,
                                  input logic [31:0] wdata, input logic [3:0] wstrb);
        set_fields(idx, addr, wdata, wstrb);
        if (idx) begin
            bus.m1_we = we; bus.m1_req = 1'b1;
        end else begin
            bus.m0_we = we; bus.m0_req = 1'b1;
        end
    endtask

    task automatic release_req(input logic idx);
        if (idx) bus.m1_req = 1'b0;
        else     bus.m0_req = 1'b0;
    endtask

    // Wait for the grant, check the downstream fields, ack after a delay, then check the completion.
    task automatic expect_grant(input logic idx, input logic we, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [3:0] wstrb,
                                input int exp_wait, input int ack_delay,
                                input logic [31:0] ack_rdata, input logic wiggle);
        exp_t e;
        int   waited;
        logic [3:0] exp_wstrb;
        e.idx   = idx;
        e.rdata = we ? 32'h0 : ack_rdata;
        exp_q.push_back(e);
        exp_wstrb = we ? wstrb : 4'b0000;
        waited = 0;
        while (bus.s_req !== 1'b1 && waited < 8) begin
            tick();
            waited++;
        end
        if (bus.s_req !== 1'b1) begin
            check_output("grant_timeout", {31'b0, bus.s_req}, 32'd1);
            e = exp_q.pop_back();
            return;
        end
        check_output("grant_latency", waited, exp_wait);
        check_output("s_we", {31'b0, bus.s_we}, {31'b0, we});
        check_output("s_addr", bus.s_addr, addr);
        check_output("s_wdata", bus.s_wdata, wdata);
        check_output("s_wstrb", {28'b0, bus.s_wstrb}, {28'b0, exp_wstrb});
        for (int i = 0; i < ack_delay; i++) begin
            if (wiggle) set_fields(idx, $urandom, $urandom, 4'(i));
            tick();
            check_output("s_req_hold", {31'b0, bus.s_req}, 32'd1);
            check_output("s_addr_hold", bus.s_addr, addr);
            check_output("s_wdata_hold", bus.s_wdata, wdata);
            check_output("s_wstrb_hold", {28'b0, bus.s_wstrb}, {28'b0, exp_wstrb});
        end
        if (wiggle) set_fields(idx, addr, wdata, wstrb);
        bus.s_ack   = 1'b1;
        bus.s_rdata = ack_rdata;
        tick();
        bus.s_ack   = 1'b0;
        bus.s_rdata = $urandom;
        e = exp_q.pop_front();
        check_output("s_req_in_resp", {31'b0, bus.s_req}, 32'd0);
        check_output("winner_done", {31'b0, e.idx ? bus.m1_done : bus.m0_done}, 32'd1);
        check_output("other_done", {31'b0, e.idx ? bus.m0_done : bus.m1_done}, 32'd0);
        check_output("winner_rdata", e.idx ? bus.m1_rdata : bus.m0_rdata, e.rdata);
        check_output("other_rdata", e.idx ? bus.m0_rdata : bus.m1_rdata, 32'h0);
    endtask

    task automatic check_quiet(input string tag);
        check_output({tag, "_s_req"}, {31'b0, bus.s_req}, 32'd0);
        check_output({tag, "_m0_done"}, {31'b0, bus.m0_done}, 32'd0);
        check_output({tag, "_m1_done"}, {31'b0, bus.m1_done}, 32'd0);
    endtask

    initial begin
        int order[4];
`ifdef MEM_ARBITER_RR_EN
        order = '{0, 1, 0, 1};
`else
        order = '{0, 0, 0, 0};
`endif
        // Reset state.
        rstn = 1'b0;
        zero_inputs();
        repeat (3) tick();
        check_quiet("reset");
        check_output("reset_s_we", {31'b0, bus.s_we}, 32'd0);
        check_output("reset_s_addr", bus.s_addr, 32'h0);
        check_output("reset_s_wdata", bus.s_wdata, 32'h0);
        check_output("reset_s_wstrb", {28'b0, bus.s_wstrb}, 32'd0);
        check_output("reset_m0_rdata", bus.m0_rdata, 32'h0);
        check_output("reset_m1_rdata", bus.m1_rdata, 32'h0);
        rstn = 1'b1;
        tick();

        // m0 read with zero-wait downstream.
        apply_stimulus(1'b0, 1'b0, 32'h100, 32'h0, 4'h0);
        expect_grant(1'b0, 1'b0, 32'h100, 32'h0, 4'h0, 1, 0, 32'hDEADBEEF, 1'b0);
        tick();
        release_req(1'b0);
        check_quiet("after_m0_read");
        tick();
        check_quiet("no_double_grant");

        // m1 write with a 5-cycle downstream stall while its fields wiggle.
        apply_stimulus(1'b1, 1'b1, 32'h40, 32'h12345678, 4'b0011);
        expect_grant(1'b1, 1'b1, 32'h40, 32'h12345678, 4'b0011, 1, 5, 32'hCAFEF00D, 1'b1);
        tick();
        release_req(1'b1);
        check_quiet("after_m1_write");
        tick();

        // Spurious ack while idle.
        bus.s_ack   = 1'b1;
        bus.s_rdata = 32'h55AA55AA;
        tick();
        bus.s_ack = 1'b0;
        check_quiet("spurious_ack");
        tick();
        check_quiet("spurious_ack_next");

        // Read with all strobes set must present no strobes downstream.
        apply_stimulus(1'b0, 1'b0, 32'h104, 32'h0, 4'hF);
        expect_grant(1'b0, 1'b0, 32'h104, 32'h0, 4'hF, 1, 2, 32'h0BADF00D, 1'b0);
        tick();
        release_req(1'b0);
        tick();

        // Reset in the middle of a transaction.
        apply_stimulus(1'b1, 1'b1, 32'h80, 32'h11112222, 4'hF);
        tick();
        check_output("busy_before_reset", {31'b0, bus.s_req}, 32'd1);
        #2;
        rstn = 1'b0;
        #1;
        check_output("s_req_async_drop", {31'b0, bus.s_req}, 32'd0);
        check_output("s_addr_async_clear", bus.s_addr, 32'h0);
        release_req(1'b1);
        tick();
        tick();
        rstn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_quiet("post_reset_idle");
        end

        // Both masters request continuously.
        apply_stimulus(1'b0, 1'b0, 32'h200, 32'h0, 4'h0);
        apply_stimulus(1'b1, 1'b1, 32'h300, 32'hA5A5A5A5, 4'b1100);
        for (int i = 0; i < 4; i++) begin
            if (order[i] == 1)
                expect_grant(1'b1, 1'b1, 32'h300, 32'hA5A5A5A5, 4'b1100, (i == 0) ? 1 : 2, i, 32'h1000 + i, 1'b0);
            else
                expect_grant(1'b0, 1'b0, 32'h200, 32'h0, 4'h0, (i == 0) ? 1 : 2, i, 32'h1000 + i, 1'b0);
        end
        tick();
        release_req(1'b0);
        expect_grant(1'b1, 1'b1, 32'h300, 32'hA5A5A5A5, 4'b1100, 1, 1, 32'h2000, 1'b0);
        tick();
        release_req(1'b1);
        tick();
        check_quiet("final_idle");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
